// File: rtl/exp2_seq.sv
// ---------------------------------------------------------------------------
// exp2_seq
// Sequential binary-to-one-hot decoder. An unsigned exponent is accepted over
// a valid/ready handshake and the result 1 << exponent is built by shifting a
// single set bit left one position per clock. Exponents that do not fit in
// the result (>= WIDTH, including the all-ones "not one-hot" code of the
// matching log2 encoder) produce an all-zero pattern with out_err raised.
//
// Parameters
//   WIDTH  width of the one-hot result (>= 2)
//   EXP_W  width of the exponent input (2**EXP_W > WIDTH)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    exponent offered
//   in_ready    block can accept (high only in IDLE)
//   in_exp      exponent, unsigned
//   out_valid   result available (state DONE)
//   out_ready   consumer accepts result
//   out_onehot  1 << in_exp, or all zeros on error
//   out_err     exponent was >= WIDTH
//   busy        operation in progress (state != IDLE)
// ---------------------------------------------------------------------------
module exp2_seq #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // The range limit is held one bit wider than the exponent so that WIDTH
    // itself is representable and the comparison never truncates.
    localparam logic [EXP_W:0] LIMIT = (EXP_W + 1)'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [EXP_W-1:0] cnt;
    logic             err_q;
    logic             accept;
    logic             exp_oor;

    // Handshake flags are decoded straight from the state so they are
    // correct the instant reset asserts, with no extra register delay.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign exp_oor   = ({1'b0, in_exp} >= LIMIT);

    // State register. Reset abandons any operation in flight; since
    // out_valid is decoded from the state, no partial result can escape.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. SHIFT finishes either immediately for a flagged
    // exponent or once the remaining shift count has reached zero. DONE
    // waits indefinitely for the consumer; there is no timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (err_q || (cnt == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. On accept the shifter is seeded with bit 0 and the counter
    // with the exponent; each SHIFT cycle moves the bit up by one until the
    // count is exhausted. An in-range count is at most WIDTH-1, so the bit
    // never falls off the top. The result registers are only written on the
    // way into DONE, which keeps them stable while the consumer stalls and
    // leaves them holding their last value back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            out_onehot <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr    <= WIDTH'(1);
                        cnt   <= in_exp;
                        err_q <= exp_oor;
                    end
                end
                SHIFT: begin
                    if (err_q) begin
                        out_onehot <= '0;
                        out_err    <= 1'b1;
                    end else if (cnt == '0) begin
                        out_onehot <= sr;
                        out_err    <= 1'b0;
                    end else begin
                        sr  <= sr << 1;
                        cnt <= cnt - EXP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp2_seq.sv
// ---------------------------------------------------------------------------
// tb_exp2_seq
// Scoreboard bench for exp2_seq (WIDTH=8, EXP_W=4). Every accepted exponent
// pushes its expected result (plain 1 << e, or zero with error when e >= 8)
// together with the cycle by which the result must appear. A free-running
// monitor on the falling edge compares the handshake flags and, whenever
// out_valid is high, the presented result against the head of the queue,
// popping it when the consumer takes it. Results are also fed through a
// behavioural log2 encoder to confirm the round trip.
// ---------------------------------------------------------------------------
module tb_exp2_seq;

    localparam int WIDTH = 8;
    localparam int EXP_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic             out_err;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] oh;
        logic             err;
        int               e;
        int               due;
    } expect_t;

    expect_t q[$];
    int      cyc    = 0;
    int      checks = 0;
    int      errors = 0;
    int      nacc   = 0;

    exp2_seq #(
        .WIDTH(WIDTH),
        .EXP_W(EXP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot),
        .out_err   (out_err),
        .busy      (busy)
    );

    // Free-running 100 MHz clock and a cycle counter bumped on each edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard wall-clock limit so the bench can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d",
                     name, act, req, cyc);
        end
    endtask

    // Behavioural log2 encoder: index of the single set bit, 99 otherwise.
    function automatic int log2enc(input logic [WIDTH-1:0] v);
        int idx = 99;
        int ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                ones++;
                idx = i;
            end
        end
        return (ones == 1) ? idx : 99;
    endfunction

    // Offer one exponent: wait (bounded) for in_ready, then hold in_valid
    // across exactly one rising edge.
    task automatic applyStimulus(input int e);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b1;
        in_exp   = EXP_W'(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been consumed.
    task automatic waitDrain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("drain_timeout", q.size(), 0);
    endtask

    // Monitor and scoreboard. Flags are checked against what the queue says
    // must be true; a result is compared whenever it is presented, and the
    // accept detection at the end records what the next edge will start.
    always @(negedge clk) begin
        expect_t t;
        logic    want_valid;
        if (rst) begin
            q.delete();
        end else begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, q.size() == 0});
            checkOutput("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            want_valid = (q.size() != 0) && (cyc >= q[0].due);
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, want_valid});
            if (out_valid && q.size() != 0) begin
                checkOutput("out_onehot", {24'd0, out_onehot}, {24'd0, q[0].oh});
                checkOutput("out_err", {31'd0, out_err}, {31'd0, q[0].err});
                if (!q[0].err) begin
                    checkOutput("roundtrip", log2enc(out_onehot), q[0].e);
                end
                if (out_ready) begin
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                t.e   = int'(in_exp);
                t.err = (t.e >= WIDTH);
                t.oh  = t.err ? '0 : WIDTH'(32'd1 << t.e);
                t.due = cyc + 2 + (t.err ? 0 : t.e);
                q.push_back(t);
                nacc++;
            end
        end
    end

    initial begin
        int start;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_exp    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;

        $display("[TB] sweep of in-range exponents");
        for (int e = 0; e < WIDTH; e++) begin
            applyStimulus(e);
            waitDrain(40);
        end

        $display("[TB] out-of-range exponents");
        applyStimulus(8);
        waitDrain(40);
        applyStimulus(15);
        waitDrain(40);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(5);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            in_exp   = EXP_W'($urandom_range(0, 15));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain(40);

        $display("[TB] reset mid-operation");
        applyStimulus(7);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_onehot", {24'd0, out_onehot}, 32'd0);
        checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        applyStimulus(2);
        waitDrain(40);

        $display("[TB] random traffic");
        start = nacc;
        for (int n = 0; n < 60000 && (nacc - start) < 1000; n++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_exp    = EXP_W'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 1) != 0);
        end
        checkOutput("random_accepts", ((nacc - start) >= 1000) ? 32'd1 : 32'd0, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
